dmem_master: RTL and testbench
==============================

Name: dmem_master

Overview:
Requester-side controller that drives the data memory's asynchronous-read / negedge-write interface on behalf of the processor datapath.
- Accepts one load/store request at a time over a valid/ready handshake.
- Sequences Mem_rd/Mem_wr with parameterised wait counts so read data has settled before sampling and writes span a falling edge.
- Implements byte/half stores as read-modify-write.
- Returns one response per request.

Parameters:
WordSize, 32, data/address width
RdWait, 2, cycles Mem_rd is held before Mem_DOUT is sampled (min 1; must cover memory T_rd)
WrWait, 1, cycles Mem_wr is held high (min 1; each cycle contains one negedge)

Ports:
CLK  in  1  clock; all state updates on posedge
RST_N  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  controller can accept (high only in IDLE)
req_wr  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
req_signed  in  1  loads: sign-extend sub-word data
req_addr  in  WordSize  byte address
req_wdata  in  WordSize  store data, right-justified
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  WordSize  load result (0 for stores/errors)
rsp_err  out  1  misaligned or illegal size, valid with rsp_valid
Mem_Addr  out  WordSize  word-aligned address {addr[WS-1:2],2'b00}
Mem_rd  out  1  read enable
Mem_wr  out  1  write enable
Mem_DIN  out  WordSize  write data
Mem_DOUT  in  WordSize  read data

Behaviour:
- Clock is CLK. Reset is RST_N: asynchronous, active-low.
- Reset values: state IDLE; Mem_rd, Mem_wr, Mem_Addr, Mem_DIN, rsp_valid, rsp_rdata, rsp_err all 0; req_ready=1 once RST_N is high.
- All Mem_* and rsp_* outputs are registered. req_ready = (state==IDLE).
- Accept occurs when req_valid && req_ready at a posedge (cycle 0). Request fields are latched at accept.
- Check at accept:
  - size 11 → error.
  - half with addr[0]=1 → error.
  - word with addr[1:0]!=0 → error.
  - Error path: state ERR, no memory access; rsp_valid=1, rsp_err=1 in cycle 1.
- States: IDLE, READ, WRITE, RESP. Wait counter is sized to max(RdWait, WrWait).
  - Load: IDLE→READ. Mem_rd=1 and Mem_Addr set for RdWait cycles. On the last READ posedge, sample Mem_DOUT, extract the lane, extend. →RESP. rsp_valid at cycle RdWait+1.
  - Word store: IDLE→WRITE. Mem_wr=1, Mem_DIN=wdata for WrWait cycles →RESP. rsp_valid at cycle WrWait+1.
  - Byte/half store: IDLE→READ (RdWait cycles) → merge new lane into sampled word → WRITE (WrWait cycles) →RESP. rsp_valid at cycle RdWait+WrWait+1.
  - RESP lasts one cycle, then IDLE. A new request can be accepted in the cycle after RESP.
- Mem_rd and Mem_wr are never high in the same cycle. On READ→WRITE, Mem_rd falls on the same edge Mem_wr rises.
- Mem_Addr and Mem_DIN are stable for the whole of every READ/WRITE phase. Mem_rd/Mem_wr return to 0 in RESP/IDLE.
- Lanes are little-endian: lane k = bits [8k+7:8k], with k=addr[1:0]. A half uses lanes {addr[1],0}..+1.
- Loads: byte/half are zero-extended, or sign-extended if req_signed. req_signed is ignored for word loads and for stores.
- Stores: only the addressed lane(s) change. Other bytes keep the values read in READ.
- Reset mid-operation: outputs clear immediately (async), including Mem_wr. The in-flight write may be lost, but no response is produced.
- req_valid while busy is ignored (req_ready=0). The requester must hold it.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - state enum IDLE/READ/WRITE/RESP/ERR.
  - function misaligned(size, addr).
- Sub-module dmem_lane_unit (combinational): extract/extend for loads and merge for stores, from (word, size, addr[1:0], signed, wdata).

Test Plan:
- Word store addr 0x10 data 0xDEADBEEF, then word load 0x10 → Mem_wr high exactly WrWait cycles with Mem_Addr=0x10; load rsp_rdata=0xDEADBEEF at cycle RdWait+1; Mem_rd/Mem_wr never overlap.
- With memory word 0x11223344: byte store 0xAA at 0x13 → memory becomes 0xAA223344; rsp_valid at cycle RdWait+WrWait+1.
- Memory 0x80FF7F01:
  - signed byte load at 0x2 → 0xFFFFFFFF.
  - unsigned half load at 0x2 → 0x000080FF.
  - signed half load at 0x0 → 0x00007F01.
- Misaligned word load at 0x6, and size 11 → rsp_valid with rsp_err=1 at cycle 1; Mem_rd/Mem_wr stay 0; rsp_rdata=0.
- Back-to-back: req_valid held high for 3 requests → each accepted only when req_ready=1; exactly 3 rsp_valid pulses, in order.
- Assert RST_N=0 during a WRITE cycle → Mem_wr drops before the next posedge; no rsp_valid; after release req_ready=1 and the next load completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and alignment check for the data-memory master
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_READ  = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
   localparam logic [2:0] ST_RESP  = 3'd3;
   localparam logic [2:0] ST_ERR   = 3'd4;

   // Size 11 is reported through the same error path as a misaligned access.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lane[0];
         SZ_WORD: bad = (lane != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// rtl/dmem_lane_unit.sv - little-endian lane extract/extend for loads and lane merge for stores
module dmem_lane_unit
   import dmem_pkg::*;
#(
   parameter int WordSize = 32
) (
   input  logic [WordSize-1:0] word,
   input  logic [1:0]          size,
   input  logic [1:0]          lane,
   input  logic                sgn,
   input  logic [WordSize-1:0] wdata,
   output logic [WordSize-1:0] load_data,
   output logic [WordSize-1:0] merged
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = word[{lane, 3'b000} +: 8];
   assign half_sel = word[{lane[1], 4'b0000} +: 16];

   always_comb begin
      load_data = word;
      merged    = wdata;
      case (size)
         SZ_BYTE: begin
            load_data = {{(WordSize-8){sgn & byte_sel[7]}}, byte_sel};
            merged    = word;
            merged[{lane, 3'b000} +: 8] = wdata[7:0];
         end
         SZ_HALF: begin
            load_data = {{(WordSize-16){sgn & half_sel[15]}}, half_sel};
            merged    = word;
            merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_master.sv
// rtl/dmem_master.sv - load/store sequencer for the async-read / negedge-write data memory
module dmem_master
   import dmem_pkg::*;
#(
   parameter int WordSize = 32,
   parameter int RdWait   = 2,
   parameter int WrWait   = 1
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_wr,
   input  logic [1:0]          req_size,
   input  logic                req_signed,
   input  logic [WordSize-1:0] req_addr,
   input  logic [WordSize-1:0] req_wdata,
   output logic                rsp_valid,
   output logic [WordSize-1:0] rsp_rdata,
   output logic                rsp_err,
   output logic [WordSize-1:0] Mem_Addr,
   output logic                Mem_rd,
   output logic                Mem_wr,
   output logic [WordSize-1:0] Mem_DIN,
   input  logic [WordSize-1:0] Mem_DOUT
);

   localparam int MaxWait = (RdWait > WrWait) ? RdWait : WrWait;
   localparam int CntW    = (MaxWait > 1) ? $clog2(MaxWait + 1) : 1;
   localparam logic [CntW-1:0] RdLast = CntW'(RdWait - 1);
   localparam logic [CntW-1:0] WrLast = CntW'(WrWait - 1);

   logic [2:0]          state;
   logic [CntW-1:0]     cnt;
   logic                l_wr;
   logic [1:0]          l_size;
   logic                l_signed;
   logic [1:0]          l_lane;
   logic [WordSize-1:0] l_wdata;
   logic [WordSize-1:0] load_data;
   logic [WordSize-1:0] merged;

   assign req_ready = (state == ST_IDLE);

   // Mem_DOUT feeds the lane unit directly; it is only captured on the last READ edge.
   dmem_lane_unit #(.WordSize(WordSize)) u_lane (
      .word      (Mem_DOUT),
      .size      (l_size),
      .lane      (l_lane),
      .sgn       (l_signed),
      .wdata     (l_wdata),
      .load_data (load_data),
      .merged    (merged)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         l_wr      <= 1'b0;
         l_size    <= SZ_BYTE;
         l_signed  <= 1'b0;
         l_lane    <= 2'b00;
         l_wdata   <= '0;
         Mem_Addr  <= '0;
         Mem_DIN   <= '0;
         Mem_rd    <= 1'b0;
         Mem_wr    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  l_wr     <= req_wr;
                  l_size   <= req_size;
                  l_signed <= req_signed;
                  l_lane   <= req_addr[1:0];
                  l_wdata  <= req_wdata;
                  if (misaligned(req_size, req_addr[1:0])) begin
                     state     <= ST_ERR;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     Mem_Addr <= {req_addr[WordSize-1:2], 2'b00};
                     if (req_wr && req_size == SZ_WORD) begin
                        state   <= ST_WRITE;
                        Mem_wr  <= 1'b1;
                        Mem_DIN <= req_wdata;
                        cnt     <= WrLast;
                     end else begin
                        // Loads and sub-word stores both start by reading the word.
                        state  <= ST_READ;
                        Mem_rd <= 1'b1;
                        cnt    <= RdLast;
                     end
                  end
               end
            end
            ST_READ: begin
               if (cnt == '0) begin
                  Mem_rd <= 1'b0;
                  if (l_wr) begin
                     state   <= ST_WRITE;
                     Mem_wr  <= 1'b1;
                     Mem_DIN <= merged;
                     cnt     <= WrLast;
                  end else begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= load_data;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_WRITE: begin
               if (cnt == '0) begin
                  Mem_wr    <= 1'b0;
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RESP, ST_ERR: begin
               state     <= ST_IDLE;
               rsp_rdata <= '0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_master.sv
// tb/tb_dmem_master.sv - self-checking bench for dmem_master against a word-array memory model
module tb_dmem_master;

   localparam int WS = 32;
   localparam int RD = 2;
   localparam int WR = 1;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_wr = 1'b0;
   logic [1:0]    req_size = 2'b00;
   logic          req_signed = 1'b0;
   logic [WS-1:0] req_addr = '0;
   logic [WS-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic [WS-1:0] rsp_rdata;
   logic          rsp_err;
   logic [WS-1:0] Mem_Addr;
   logic          Mem_rd;
   logic          Mem_wr;
   logic [WS-1:0] Mem_DIN;
   logic [WS-1:0] Mem_DOUT;

   logic [31:0] mem     [0:15];
   logic [31:0] ref_mem [0:15];

   int checks = 0;
   int errors = 0;

   dmem_master #(.WordSize(WS), .RdWait(RD), .WrWait(WR)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wr     (req_wr),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .Mem_Addr   (Mem_Addr),
      .Mem_rd     (Mem_rd),
      .Mem_wr     (Mem_wr),
      .Mem_DIN    (Mem_DIN),
      .Mem_DOUT   (Mem_DOUT)
   );

   always #5 CLK = ~CLK;

   assign Mem_DOUT = mem[Mem_Addr[5:2]];
   always @(negedge CLK) if (Mem_wr) mem[Mem_Addr[5:2]] <= Mem_DIN;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] a, input logic sg);
      logic [31:0] v;
      if (sz == 2'b00) begin
         v = (w >> (8 * a)) & 32'hFF;
         if (sg && v[7]) v = v | 32'hFFFFFF00;
      end else if (sz == 2'b01) begin
         v = (w >> (8 * a)) & 32'hFFFF;
         if (sg && v[15]) v = v | 32'hFFFF0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] a, input logic [31:0] d);
      logic [31:0] mask;
      mask = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFFFFFF;
      mask = mask << (8 * a);
      return (w & ~mask) | ((d << (8 * a)) & mask);
   endfunction

   task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd);
      logic [31:0] exp_rd;
      logic        exp_err;
      int exp_lat, exp_rdc, exp_wrc;
      int cyc, rdc, wrc, overlap, addr_bad, idx;
      idx = int'(addr[5:2]);
      exp_err = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
      exp_rd = '0;
      if (exp_err) begin
         exp_lat = 1; exp_rdc = 0; exp_wrc = 0;
      end else if (!wr) begin
         exp_rd = model_load(ref_mem[idx], sz, addr[1:0], sg);
         exp_lat = RD + 1; exp_rdc = RD; exp_wrc = 0;
      end else if (sz == 2'b10) begin
         ref_mem[idx] = wd;
         exp_lat = WR + 1; exp_rdc = 0; exp_wrc = WR;
      end else begin
         ref_mem[idx] = model_store(ref_mem[idx], sz, addr[1:0], wd);
         exp_lat = RD + WR + 1; exp_rdc = RD; exp_wrc = WR;
      end

      @(negedge CLK);
      req_valid = 1'b1; req_wr = wr; req_size = sz; req_signed = sg;
      req_addr = addr; req_wdata = wd;
      cyc = 0;
      while (!req_ready && cyc < 50) begin
         @(negedge CLK);
         cyc++;
      end
      check("ready_before_accept", {31'd0, req_ready}, 32'd1);
      @(posedge CLK);
      #1 req_valid = 1'b0;
      req_addr = $urandom;
      req_wdata = $urandom;

      cyc = 0; rdc = 0; wrc = 0; overlap = 0; addr_bad = 0;
      do begin
         @(negedge CLK);
         cyc++;
         if (Mem_rd) rdc++;
         if (Mem_wr) wrc++;
         if (Mem_rd && Mem_wr) overlap++;
         if ((Mem_rd || Mem_wr) && Mem_Addr !== {addr[31:2], 2'b00}) addr_bad++;
      end while (!rsp_valid && cyc < 50);

      check("rsp_latency", cyc, exp_lat);
      check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("rd_cycles", rdc, exp_rdc);
      check("wr_cycles", wrc, exp_wrc);
      check("rd_wr_overlap", overlap, 0);
      check("addr_stable", addr_bad, 0);
      @(negedge CLK);
      check("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
      check("idle_strobes", {30'd0, Mem_rd, Mem_wr}, 32'd0);
      check("ready_after", {31'd0, req_ready}, 32'd1);
      check("mem_word", mem[idx], ref_mem[idx]);
   endtask

   initial begin
      logic [31:0] ba [3];
      logic [31:0] be [3];
      int nacc, nrsp, cyc, idx;
      logic acc;

      for (int i = 0; i < 16; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      #1;
      check("rst_mem_rd", {31'd0, Mem_rd}, 32'd0);
      check("rst_mem_wr", {31'd0, Mem_wr}, 32'd0);
      check("rst_mem_addr", Mem_Addr, 32'd0);
      check("rst_mem_din", Mem_DIN, 32'd0);
      check("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      check("rst_ready", {31'd0, req_ready}, 32'd1);

      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
      do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000AA);
      check("byte_store_result", ref_mem[4], 32'hAA223344);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

      do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h80FF7F01);
      do_req(1'b0, 2'b00, 1'b1, 32'h2, 32'h0);
      do_req(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
      do_req(1'b0, 2'b01, 1'b1, 32'h0, 32'h0);
      do_req(1'b0, 2'b00, 1'b0, 32'h3, 32'h0);
      do_req(1'b1, 2'b01, 1'b0, 32'h2, 32'h0000C0DE);

      do_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
      do_req(1'b0, 2'b11, 1'b0, 32'h8, 32'h0);
      do_req(1'b1, 2'b01, 1'b0, 32'h5, 32'h1234);

      for (int n = 0; n < 40; n++) begin
         logic [1:0] sz;
         sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         do_req(1'($urandom), sz, 1'($urandom), 32'($urandom_range(0, 63)), $urandom);
      end

      // back-to-back: valid held high across three loads
      for (int i = 0; i < 3; i++) begin
         ba[i] = 32'($urandom_range(0, 15)) * 4;
         be[i] = ref_mem[ba[i][5:2]];
      end
      @(negedge CLK);
      req_valid = 1'b1; req_wr = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = ba[0];
      nacc = 0; nrsp = 0; cyc = 0;
      while (nrsp < 3 && cyc < 100) begin
         acc = req_valid && req_ready;
         @(posedge CLK);
         #1;
         if (acc) begin
            nacc++;
            if (nacc < 3) req_addr = ba[nacc];
            else req_valid = 1'b0;
         end
         @(negedge CLK);
         cyc++;
         if (rsp_valid) begin
            check("b2b_rdata", rsp_rdata, be[nrsp]);
            nrsp++;
         end
      end
      repeat (6) begin
         @(negedge CLK);
         if (rsp_valid) nrsp++;
      end
      check("b2b_accepts", nacc, 3);
      check("b2b_responses", nrsp, 3);

      // reset during a write
      @(negedge CLK);
      req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b10; req_addr = 32'h3C; req_wdata = $urandom;
      @(posedge CLK);
      #1 req_valid = 1'b0;
      @(negedge CLK);
      check("rstmid_wr_high", {31'd0, Mem_wr}, 32'd1);
      #2 RST_N = 1'b0;
      #1;
      check("rstmid_wr_drop", {31'd0, Mem_wr}, 32'd0);
      check("rstmid_no_rsp", {31'd0, rsp_valid}, 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      idx = 15;
      ref_mem[idx] = mem[idx];
      cyc = 0;
      repeat (4) begin
         @(negedge CLK);
         if (rsp_valid) cyc++;
      end
      check("rstmid_quiet", cyc, 0);
      check("rstmid_ready", {31'd0, req_ready}, 32'd1);
      do_req(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
      do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
